// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: load-use stalls, branch flushes and multi-cycle memory waits.
// Outputs are combinational from the registered state and the current inputs.
module pipe_hazard_unit #(
    parameter int REG_W         = 4,
    parameter int LOAD_LAT      = 1,
    parameter int ZERO_REG_SAFE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_src,
    input  logic             idex_mem_read,
    input  logic             idex_reg_write,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic [REG_W-1:0] idex_rd,
    input  logic             mem_busy,
    output logic             wr_pc,
    output logic             im_read,
    output logic             wr_ifid,
    output logic             wr_idex,
    output logic             wr_exmem,
    output logic             wr_memwb,
    output logic             ifid_clear,
    output logic             idex_clear,
    output logic             exmem_clear,
    output logic             memwb_clear,
    output logic             stall_active,
    output logic [15:0]      stall_count
);

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

    localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

    state_t      r_state, r_saved;
    logic [2:0]  r_lu_cnt;
    logic [15:0] r_stall_count;

    state_t      w_state_nxt, w_saved_nxt, w_eff;
    logic [2:0]  w_lu_cnt_nxt;
    logic        w_hazard;
    logic        w_zero_rd;

    assign w_zero_rd = (ZERO_REG_SAFE != 0) && (idex_rd == '0);
    assign w_hazard  = idex_mem_read && idex_reg_write &&
                       ((ifid_rs == idex_rd) || (ifid_rt == idex_rd)) && !w_zero_rd;

    // While waiting on memory with mem_busy low, behave as the state saved on entry.
    assign w_eff = (r_state == MEM_WAIT) ? r_saved : r_state;

    always_comb begin
        wr_pc        = 1'b1;
        im_read      = 1'b1;
        wr_ifid      = 1'b1;
        wr_idex      = 1'b1;
        wr_exmem     = 1'b1;
        wr_memwb     = 1'b1;
        ifid_clear   = 1'b0;
        idex_clear   = 1'b0;
        exmem_clear  = 1'b0;
        memwb_clear  = 1'b0;
        w_state_nxt  = RUN;
        w_saved_nxt  = r_saved;
        w_lu_cnt_nxt = r_lu_cnt;

        if (rst) begin
            wr_pc        = 1'b0;
            im_read      = 1'b0;
            wr_ifid      = 1'b0;
            wr_idex      = 1'b0;
            wr_exmem     = 1'b0;
            wr_memwb     = 1'b0;
            ifid_clear   = 1'b1;
            idex_clear   = 1'b1;
            exmem_clear  = 1'b1;
            memwb_clear  = 1'b1;
            w_saved_nxt  = RUN;
            w_lu_cnt_nxt = 3'd0;
        end else if (mem_busy) begin
            wr_pc       = 1'b0;
            im_read     = 1'b0;
            wr_ifid     = 1'b0;
            wr_idex     = 1'b0;
            wr_exmem    = 1'b0;
            wr_memwb    = 1'b0;
            w_state_nxt = MEM_WAIT;
            if (r_state != MEM_WAIT)
                w_saved_nxt = r_state;
        end else if (pc_src) begin
            ifid_clear   = 1'b1;
            idex_clear   = 1'b1;
            exmem_clear  = 1'b1;
            w_lu_cnt_nxt = 3'd0;
        end else if (w_eff == LU_STALL || w_hazard) begin
            wr_pc      = 1'b0;
            im_read    = 1'b0;
            wr_ifid    = 1'b0;
            idex_clear = 1'b1;
            if (w_eff == LU_STALL) begin
                if (r_lu_cnt <= 3'd1) begin
                    w_lu_cnt_nxt = 3'd0;
                end else begin
                    w_state_nxt  = LU_STALL;
                    w_lu_cnt_nxt = r_lu_cnt - 3'd1;
                end
            end else if (LOAD_LAT > 1) begin
                w_state_nxt  = LU_STALL;
                w_lu_cnt_nxt = LAT_M1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_saved  <= RUN;
            r_lu_cnt <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_saved  <= w_saved_nxt;
            r_lu_cnt <= w_lu_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_count <= 16'd0;
        else if (!wr_pc && r_stall_count != 16'hFFFF)
            r_stall_count <= r_stall_count + 16'd1;
    end

    assign stall_count  = r_stall_count;
    assign stall_active = !rst && ((r_state != RUN) || w_hazard || mem_busy);

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench: four hazard units with different LOAD_LAT / ZERO_REG_SAFE share one stimulus.
module tb_pipe_hazard_unit;

    localparam logic [9:0] NORM  = 10'b111111_0000;
    localparam logic [9:0] STALL = 10'b000111_0100;
    localparam logic [9:0] MEMW  = 10'b000000_0000;
    localparam logic [9:0] FLUSH = 10'b111111_1110;
    localparam logic [9:0] RSTV  = 10'b000000_1111;
    localparam int K_CTRL = 0, K_CNT = 1, K_SA = 2;

    typedef struct {
        string       name;
        int          dut;
        int          kind;
        logic [15:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst, pc_src, idex_mem_read, idex_reg_write, mem_busy;
    logic [3:0] ifid_rs, ifid_rt, idex_rd;

    logic [3:0][9:0]  ctrl;
    logic [3:0]       sa;
    logic [3:0][15:0] sc;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // dut 0: LAT1/ZRS1, dut 1: LAT3, dut 2: LAT2, dut 3: LAT1/ZRS0
    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic wp, ir, wi, wd, we, wm, ci, cd, ce, cm, act;
        logic [15:0] cnt;
        pipe_hazard_unit #(
            .REG_W(4),
            .LOAD_LAT(g == 1 ? 3 : (g == 2 ? 2 : 1)),
            .ZERO_REG_SAFE(g == 3 ? 0 : 1)
        ) u_dut (
            .clk(clk), .rst(rst), .pc_src(pc_src),
            .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write),
            .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rd(idex_rd),
            .mem_busy(mem_busy),
            .wr_pc(wp), .im_read(ir), .wr_ifid(wi), .wr_idex(wd),
            .wr_exmem(we), .wr_memwb(wm),
            .ifid_clear(ci), .idex_clear(cd), .exmem_clear(ce), .memwb_clear(cm),
            .stall_active(act), .stall_count(cnt)
        );
        assign ctrl[g] = {wp, ir, wi, wd, we, wm, ci, cd, ce, cm};
        assign sa[g]   = act;
        assign sc[g]   = cnt;
    end

    function automatic logic [15:0] actual(int d, int k);
        if (k == K_CTRL) return {6'd0, ctrl[d]};
        if (k == K_CNT)  return sc[d];
        return {15'd0, sa[d]};
    endfunction

    task automatic push(string name, int d, int k, logic [15:0] e);
        exp_t x;
        x.name = name; x.dut = d; x.kind = k; x.exp = e;
        q.push_back(x);
    endtask

    task automatic idle();
        rst = 0; pc_src = 0; idex_mem_read = 0; idex_reg_write = 0; mem_busy = 0;
        ifid_rs = 4'd0; ifid_rt = 4'd0; idex_rd = 4'd0;
    endtask

    task automatic hazard();
        idex_mem_read = 1; idex_reg_write = 1; idex_rd = 4'd3; ifid_rs = 4'd3; ifid_rt = 4'd7;
    endtask

    // Sample outputs mid-cycle, drain the scoreboard, then advance past the edge.
    task automatic step();
        exp_t x;
        logic [15:0] a;
        @(negedge clk);
        while (q.size() > 0) begin
            x = q.pop_front();
            a = actual(x.dut, x.kind);
            checks++;
            if (a !== x.exp) begin
                errors++;
                $display("FAIL %s dut%0d: got %h expected %h", x.name, x.dut, a, x.exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle(); rst = 1;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle(); rst = 1; hazard(); pc_src = 1; mem_busy = 1;
        for (int d = 0; d < 4; d++) begin
            push("rst_ctrl", d, K_CTRL, {6'd0, RSTV});
            push("rst_active", d, K_SA, 16'd0);
        end
        step();
        idle();
        for (int d = 0; d < 4; d++) begin
            push("rst_cnt", d, K_CNT, 16'd0);
            push("post_rst", d, K_CTRL, {6'd0, NORM});
        end
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        hazard();
        for (int d = 0; d < 4; d++) begin
            push("lu_c0", d, K_CTRL, {6'd0, STALL});
            push("lu_c0_act", d, K_SA, 16'd1);
        end
        step();
        idle();
        push("lu_c1", 0, K_CTRL, {6'd0, NORM});
        push("lu_c1", 1, K_CTRL, {6'd0, STALL});
        push("lu_c1", 2, K_CTRL, {6'd0, STALL});
        push("lu_c1_act", 1, K_SA, 16'd1);
        step();
        push("lu_c2", 1, K_CTRL, {6'd0, STALL});
        push("lu_c2", 2, K_CTRL, {6'd0, NORM});
        step();
        push("lu_c3", 1, K_CTRL, {6'd0, NORM});
        push("lu_c3_act", 1, K_SA, 16'd0);
        step();
        push("lu_cnt", 0, K_CNT, 16'd1);
        push("lu_cnt", 1, K_CNT, 16'd3);
        push("lu_cnt", 2, K_CNT, 16'd2);
        push("lu_cnt", 3, K_CNT, 16'd1);
        step();
    endtask

    task automatic test_pc_src_abort();
        do_reset();
        hazard();
        push("br_c0", 1, K_CTRL, {6'd0, STALL});
        step();
        idle(); pc_src = 1;
        for (int d = 0; d < 3; d++) push("br_c1", d, K_CTRL, {6'd0, FLUSH});
        step();
        idle();
        push("br_c2", 1, K_CTRL, {6'd0, NORM});
        step();
        push("br_cnt", 1, K_CNT, 16'd1);
        push("br_cnt", 2, K_CNT, 16'd1);
        step();
    endtask

    task automatic test_mem_busy();
        do_reset();
        hazard();
        push("mb_c0", 2, K_CTRL, {6'd0, STALL});
        step();
        idle(); mem_busy = 1;
        for (int c = 1; c <= 2; c++) begin
            for (int d = 0; d < 3; d++) push("mb_wait", d, K_CTRL, {6'd0, MEMW});
            push("mb_act", 2, K_SA, 16'd1);
            step();
        end
        idle();
        push("mb_c3", 2, K_CTRL, {6'd0, STALL});
        push("mb_c3", 1, K_CTRL, {6'd0, STALL});
        push("mb_c3", 0, K_CTRL, {6'd0, NORM});
        step();
        push("mb_c4", 2, K_CTRL, {6'd0, NORM});
        push("mb_c4", 1, K_CTRL, {6'd0, STALL});
        step();
        push("mb_c5", 1, K_CTRL, {6'd0, NORM});
        push("mb_cnt", 2, K_CNT, 16'd4);
        push("mb_cnt", 0, K_CNT, 16'd3);
        step();
        push("mb_cnt", 1, K_CNT, 16'd5);
        step();
    endtask

    task automatic test_zero_reg();
        do_reset();
        idex_mem_read = 1; idex_reg_write = 1; idex_rd = 4'd0; ifid_rt = 4'd0; ifid_rs = 4'd5;
        push("zr_safe", 0, K_CTRL, {6'd0, NORM});
        push("zr_safe_act", 0, K_SA, 16'd0);
        push("zr_unsafe", 3, K_CTRL, {6'd0, STALL});
        step();
        idle();
        push("zr_after", 3, K_CTRL, {6'd0, NORM});
        step();
        push("zr_cnt", 0, K_CNT, 16'd0);
        push("zr_cnt", 3, K_CNT, 16'd1);
        step();
    endtask

    task automatic test_priority();
        do_reset();
        hazard(); pc_src = 1; mem_busy = 1;
        for (int d = 0; d < 4; d++) push("pri_mem", d, K_CTRL, {6'd0, MEMW});
        step();
        mem_busy = 0;
        for (int d = 0; d < 4; d++) push("pri_br", d, K_CTRL, {6'd0, FLUSH});
        step();
        pc_src = 0;
        push("pri_haz", 1, K_CTRL, {6'd0, STALL});
        step();
        idle(); rst = 1;
        push("pri_rst", 1, K_CTRL, {6'd0, RSTV});
        step();
        idle();
        push("pri_abort", 1, K_CTRL, {6'd0, NORM});
        push("pri_abort_cnt", 1, K_CNT, 16'd0);
        step();
    endtask

    task automatic test_saturate();
        do_reset();
        mem_busy = 1;
        repeat (65535) step();
        push("sat_full", 0, K_CNT, 16'hFFFF);
        step();
        push("sat_hold", 0, K_CNT, 16'hFFFF);
        idle(); rst = 1;
        step();
        idle();
        push("sat_clear", 0, K_CNT, 16'd0);
        step();
    endtask

    initial begin
        idle(); rst = 1;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_pc_src_abort();
        test_mem_busy();
        test_zero_reg();
        test_priority();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
